// File: rtl/sobel_row_buffer.sv
// Three-row sliding window between the Sobel read transform and accumulator.
// Captures one row segment per accepted load and hands out full windows.
module sobel_row_buffer #(
    parameter int IDATA_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sctl2srow_load,
    input  logic                   sctl2srow_new_col,
    input  logic [IDATA_WIDTH-1:0] srt2srow_read_data,
    output logic                   srow2sctl_load_ready,
    output logic                   srow2sctl_overrun,
    output logic [IDATA_WIDTH-1:0] srow2sacc_row_top,
    output logic [IDATA_WIDTH-1:0] srow2sacc_row_mid,
    output logic [IDATA_WIDTH-1:0] srow2sacc_row_bot,
    output logic                   srow2sacc_valid,
    input  logic                   sacc2srow_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL1 = 2'd1,
        FILL2 = 2'd2,
        FULL  = 2'd3
    } fill_t;

    fill_t                  r_state;
    fill_t                  w_state_nxt;
    logic                   r_pending;
    logic                   r_fresh;
    logic                   r_overrun;
    logic [IDATA_WIDTH-1:0] r_top;
    logic [IDATA_WIDTH-1:0] r_mid;
    logic [IDATA_WIDTH-1:0] r_bot;

    logic w_load_ready;
    logic w_accept;
    logic w_reject;
    logic w_capture;
    logic w_consume;
    logic w_fresh_nxt;

    assign w_load_ready = !r_pending && !r_fresh;
    // A new strip overrides any in-flight or unconsumed state.
    assign w_accept     = sctl2srow_load &&
                          (w_load_ready || sctl2srow_new_col);
    assign w_reject     = sctl2srow_load && !w_accept;
    assign w_capture    = r_pending && !sctl2srow_new_col;
    assign w_consume    = r_fresh && sacc2srow_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_fresh_nxt = r_fresh;
        if (sctl2srow_new_col) begin
            w_state_nxt = EMPTY;
            w_fresh_nxt = 1'b0;
        end else if (w_capture) begin
            case (r_state)
                EMPTY:   w_state_nxt = FILL1;
                FILL1:   w_state_nxt = FILL2;
                default: w_state_nxt = FULL;
            endcase
            w_fresh_nxt = (w_state_nxt == FULL);
        end else if (w_consume) begin
            w_fresh_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= EMPTY;
            r_pending <= 1'b0;
            r_fresh   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_accept;
            r_fresh   <= w_fresh_nxt;
            if (w_reject) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_top <= '0;
            r_mid <= '0;
            r_bot <= '0;
        end else if (w_capture) begin
            r_top <= r_mid;
            r_mid <= r_bot;
            r_bot <= srt2srow_read_data;
        end
    end

    assign srow2sctl_load_ready = w_load_ready;
    assign srow2sctl_overrun    = r_overrun;
    assign srow2sacc_row_top    = r_top;
    assign srow2sacc_row_mid    = r_mid;
    assign srow2sacc_row_bot    = r_bot;
    assign srow2sacc_valid      = r_fresh;

endmodule

// File: doc/sobel_row_buffer.md
# sobel_row_buffer

Three-row sliding window buffer directly downstream of the Sobel read transform stage. It captures the byte-ordered read data one cycle after the controller issues each row read. It maintains a top/middle/bottom window of `IDATA_WIDTH`-bit row segments and presents complete windows to the Sobel accumulator through a valid/ready handshake. It also back-pressures the controller so that an unconsumed window is never overwritten.

## Interface
- `IDATA_WIDTH`, default `SOBEL_IDATA_WIDTH` (64): width of one row segment delivered per read.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; low forces all state to reset values immediately.
- `sctl2srow_load`  in  1  controller issued a row read this cycle; the data arrives next cycle.
- `sctl2srow_new_col`  in  1  start of a new column strip; the window is discarded.
- `srt2srow_read_data`  in  `IDATA_WIDTH`  transformed read data, valid exactly one cycle after an accepted load.
- `srow2sctl_load_ready`  out  1  a load presented this cycle will be accepted.
- `srow2sctl_overrun`  out  1  sticky error: a load was presented while `load_ready` was low.
- `srow2sacc_row_top`, `srow2sacc_row_mid`, `srow2sacc_row_bot`  out  `IDATA_WIDTH` each  window rows, oldest to newest.
- `srow2sacc_valid`  out  1  the window holds three rows and has not been consumed.
- `sacc2srow_ready`  in  1  the accumulator accepts the window this cycle.

## Operation
- **State:**
  - three row registers (`top`, `mid`, `bot`);
  - 2-bit fill count `cnt` (0..3, saturating);
  - `pending` flag (load in flight);
  - `fresh` flag (window unconsumed);
  - sticky `overrun` flag.
- **Fill states by `cnt`:**
  - EMPTY (0) → FILL1 (1) → FILL2 (2) → FULL (3), advancing on each capture.
  - FULL stays FULL on further captures.
- **Load acceptance:** `load_ready = !pending && !fresh`. This is combinational from registers only and does not depend on `sacc2srow_ready`.
- **Accepted load:** `sctl2srow_load && load_ready` sets `pending`.
- **Rejected load:** `sctl2srow_load && !load_ready` is ignored (no state change except `overrun` ← 1). `overrun` clears only on reset.
- **Capture** occurs in the cycle where `pending` = 1:
  - `top` ← `mid`, `mid` ← `bot`, `bot` ← `srt2srow_read_data`;
  - `cnt` ← min(`cnt`+1, 3);
  - `pending` ← 0;
  - if the new `cnt` is 3, `fresh` ← 1.
- **Handshake:**
  - `srow2sacc_valid = fresh`.
  - Consume (`valid && ready`) clears `fresh`.
  - `ready` while `valid` is low has no effect.
  - Row outputs are held stable while `valid` is high.
- **Steady state:** after the first full window, each further capture shifts one row and produces a new window (vertical slide by one row).
- **`sctl2srow_new_col` (highest priority):**
  - `cnt` ← 0, `fresh` ← 0, `pending` ← 0.
  - Any capture due that cycle is discarded.
  - Row registers are not cleared, but are invisible because `valid` = 0.
  - A load in the same cycle as `new_col` is accepted regardless of the old `pending`/`fresh` (`pending` ← 1) and becomes the first row of the new strip.
- **Capture and consume in the same cycle:** cannot occur, because a load cannot be accepted while `fresh` = 1.
- **Reset values:**
  - all row outputs 0;
  - `valid` 0, `overrun` 0, `cnt` 0, `pending` 0, `fresh` 0;
  - `load_ready` 1.
- **Reset asserted mid-operation:** everything returns to reset values asynchronously. In-flight data arriving after reset release is ignored because `pending` = 0.

## Timing
- Load accepted in cycle t; data sampled on `srt2srow_read_data` in cycle t+1; rows updated at the end of t+1.
- From an empty window, `valid` first rises in cycle t+2 of the third accepted load.
- Maximum load rate is one per 2 cycles (`pending` blocks the next cycle).
- In FULL, a new load is possible in the cycle after consume. Best-case steady-state window rate is one per 3 cycles (load, capture, consume).
- `load_ready` drops in the cycle after an accepted load and stays low while a window is unconsumed.
- No combinational path from any input to any output.

## Test plan
- **Reset:** hold `reset` = 0 mid-fill, then release → all outputs 0, `load_ready` = 1, and the in-flight data word is not captured.
- **Fill:** three loads with data 0x11…, 0x22…, 0x33… (each repeated across 64 bits), `ready` = 0 → `valid` rises 2 cycles after the third load; top = 0x11…, mid = 0x22…, bot = 0x33…; `load_ready` = 0 and the rows are held while stalled.
- **Slide:** consume, then load 0x44… → `valid` drops for 2 cycles, then returns with top = 0x22…, mid = 0x33…, bot = 0x44….
- **Overrun:**
  - load on the cycle right after an accepted load → ignored, `overrun` = 1 and stays 1;
  - window contents are unchanged.
- **New column:** assert `new_col` in the cycle data 0x55… is due, together with a load → 0x55… is discarded; three further captures are needed before `valid`; the first row of the new strip comes from the co-issued load.
- **Stall:** hold `ready` low for 10 cycles with `valid` high → outputs stable and `load_ready` = 0 throughout; after `ready` rises, `valid` falls next cycle.
